// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit every two clocks behind a start/ready/done handshake.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module restoring_divider_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

`ifdef SIGNED_DIV_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SUB     = 3'd2,
      RESTORE = 3'd3,
      FIX     = 3'd4,
      DONE    = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SUB     = 3'd2,
      RESTORE = 3'd3,
      DONE    = 3'd5
   } state_t;
`endif

   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   // Shifted {A,Q} pair used by the SUB step.
   logic [WIDTH:0]   a_shift;
   logic [WIDTH-1:0] q_shift;
   logic [WIDTH:0]   a_restored;

`ifdef SIGNED_DIV_EN
   logic neg_n_q, neg_n_d;
   logic neg_d_q, neg_d_d;
   logic [WIDTH-1:0] q_abs, m_abs;
`endif

   assign a_shift    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign q_shift    = {q_q[WIDTH-2:0], 1'b0};
   assign a_restored = a_q + {1'b0, m_q};

`ifdef SIGNED_DIV_EN
   assign q_abs = q_q[WIDTH-1] ? (~q_q + ONE_W) : q_q;
   assign m_abs = m_q[WIDTH-1] ? (~m_q + ONE_W) : m_q;
`endif

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
      neg_n_d     = neg_n_q;
      neg_d_d     = neg_d_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               q_d     = dividend_i;
               m_d     = divisor_i;
               state_d = LOAD;
            end
         end

         LOAD: begin
            a_d   = '0;
            cnt_d = CNT_MAX;
`ifdef SIGNED_DIV_EN
            neg_n_d = q_q[WIDTH-1];
            neg_d_d = m_q[WIDTH-1];
            q_d     = q_abs;
            m_d     = m_abs;
`endif
            if (m_q == '0) begin
               // Raw dividend (before any magnitude conversion) is reported as the remainder.
               quotient_d  = '1;
               remainder_d = q_q;
               dbz_d       = 1'b1;
               state_d     = DONE;
            end else begin
               state_d = SUB;
            end
         end

         SUB: begin
            a_d     = a_shift - {1'b0, m_q};
            q_d     = q_shift;
            state_d = RESTORE;
         end

         RESTORE: begin
            if (a_q[WIDTH]) begin
               a_d     = a_restored;
               q_d[0]  = 1'b0;
            end else begin
               q_d[0]  = 1'b1;
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_d == '0) begin
`ifdef SIGNED_DIV_EN
               state_d = FIX;
`else
               // Results are loaded on the edge into DONE so they are valid alongside done.
               quotient_d  = q_d;
               remainder_d = a_d[WIDTH-1:0];
               dbz_d       = 1'b0;
               state_d     = DONE;
`endif
            end else begin
               state_d = SUB;
            end
         end

`ifdef SIGNED_DIV_EN
         FIX: begin
            quotient_d  = (neg_n_q ^ neg_d_q) ? (~q_q + ONE_W) : q_q;
            remainder_d = neg_n_q ? (~a_q[WIDTH-1:0] + ONE_W) : a_q[WIDTH-1:0];
            dbz_d       = 1'b0;
            state_d     = DONE;
         end
`endif

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

`ifdef SIGNED_DIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_n_q <= 1'b0;
         neg_d_q <= 1'b0;
      end else begin
         neg_n_q <= neg_n_d;
         neg_d_q <= neg_d_d;
      end
   end
`endif

   assign ready_o       = (state_q == IDLE);
   assign done_o        = (state_q == DONE);
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Randomised and directed checks of restoring_divider_seq against a plain-arithmetic reference model.
module tb_restoring_divider_seq;

   localparam int WIDTH = 8;
`ifdef SIGNED_DIV_EN
   localparam int SGN = 1;
`else
   localparam int SGN = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_i = 1'b0;
   logic [WIDTH-1:0] dividend_i = '0;
   logic [WIDTH-1:0] divisor_i = '0;
   logic             ready_o, done_o, div_by_zero_o;
   logic [WIDTH-1:0] quotient_o, remainder_o;

   int n_tests = 0;
   int n_fail  = 0;

   restoring_divider_seq #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .ready_o      (ready_o),
      .done_o       (done_o),
      .quotient_o   (quotient_o),
      .remainder_o  (remainder_o),
      .div_by_zero_o(div_by_zero_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division (truncating toward zero in the signed build).
   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r, output logic dz);
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
`ifdef SIGNED_DIV_EN
         int sa, sb;
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = WIDTH'(sa / sb);
         r  = WIDTH'(sa % sb);
`else
         q  = a / b;
         r  = a % b;
`endif
         dz = 1'b0;
      end
   endtask

   // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
   task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke);
      logic [WIDTH-1:0] eq, er, pq, pr;
      logic             edz, pdz;
      int               lat, exp_lat;
      bit               held, busy_ok;
      model(a, b, eq, er, edz);
      exp_lat = (b == '0) ? 2 : 2 * WIDTH + 2 + SGN;
      pq = quotient_o; pr = remainder_o; pdz = div_by_zero_o;
      start_i = 1'b1; dividend_i = a; divisor_i = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      dividend_i = WIDTH'($urandom);
      divisor_i  = WIDTH'($urandom);
      lat = 0; held = 1'b1; busy_ok = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == poke) begin
            start_i = 1'b1; dividend_i = 8'd1; divisor_i = 8'd1;
         end else begin
            start_i = 1'b0;
         end
         if (done_o === 1'b1) begin
            lat = k;
            break;
         end
         if (quotient_o !== pq || remainder_o !== pr || div_by_zero_o !== pdz) held = 1'b0;
         if (ready_o !== 1'b0) busy_ok = 1'b0;
      end
      start_i = 1'b0;
      chk("latency", lat, exp_lat);
      chk("hold", 32'(held), 32'd1);
      chk("busy", 32'(busy_ok), 32'd1);
      chk("quotient", quotient_o, eq);
      chk("remainder", remainder_o, er);
      chk("div_by_zero", 32'(div_by_zero_o), 32'(edz));
      $display("[TB] %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d", a, b, quotient_o, remainder_o,
               div_by_zero_o, lat);
      @(negedge clk);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("ready_after", 32'(ready_o), 32'd1);
      chk("quot_held", quotient_o, eq);
   endtask

   task automatic no_done_for(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done_o === 1'b1) pulses++;
      end
      chk(tag, pulses, 0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_quot"}, quotient_o, 0);
      chk({tag, "_rem"}, remainder_o, 0);
      chk({tag, "_dbz"}, 32'(div_by_zero_o), 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int sel;
      #1;
      chk_reset_values("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_div(8'd100, 8'd7, 0);   // T1
      do_div(8'd255, 8'd1, 0);   // T2
      do_div(8'd7, 8'd9, 0);
      do_div(8'd5, 8'd0, 0);     // T3
      do_div(8'd6, 8'd3, 0);
      do_div(8'd200, 8'd3, 5);   // T4: second start mid-operation
      no_done_for("extra_done", 2 * WIDTH + 8);

      // T5: asynchronous reset mid-division
      start_i = 1'b1; dividend_i = 8'd50; divisor_i = 8'd3;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      no_done_for("aborted_done", 2 * WIDTH + 8);
      do_div(8'd9, 8'd4, 0);

`ifdef SIGNED_DIV_EN
      do_div(8'hF9, 8'd2, 0);
      chk("t6a_q", quotient_o, 8'hFD);
      chk("t6a_r", remainder_o, 8'hFF);
      do_div(8'd7, 8'hFE, 0);
      chk("t6b_q", quotient_o, 8'hFD);
      chk("t6b_r", remainder_o, 8'h01);
      do_div(8'h80, 8'hFF, 0);
      chk("t6c_q", quotient_o, 8'h80);
      chk("t6c_r", remainder_o, 8'h00);
`endif

      for (int i = 0; i < 40; i++) begin
         ra  = WIDTH'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      rb = '0;
         else if (sel == 1) rb = 8'd1;
         else if (sel < 5)  rb = WIDTH'($urandom_range(2, 15));
         else               rb = WIDTH'($urandom);
         do_div(ra, rb, (sel == 9) ? 3 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
